// File: rtl/fakeram130_1rw_clr.sv
// Parametrised single-port SRAM model with request handshake and hardware clear sweep.
// Latency: reads return READ_LATENCY (1 or 2) cycles after the accepting edge; writes land at that edge.
// Backpressure: ready_out is low for the whole clear sweep; requests are accepted only when ready_out=1.
module fakeram130_1rw_clr #(
    parameter int                BITS               = 64,
    parameter int                WORD_DEPTH         = 512,
    parameter int                ADDR_WIDTH         = $clog2(WORD_DEPTH),
    parameter int                READ_LATENCY       = 1,
    parameter int                CLEAR_ON_RESET     = 1,
    parameter logic [BITS-1:0]   CLEAR_VALUE        = '0,
    parameter bit                corrupt_mem_on_X_p = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce_in,
    input  logic                  we_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       w_mask_in,
    input  logic                  clr_in,
    output logic                  ready_out,
    output logic [BITS-1:0]       rd_out,
    output logic                  rd_valid_out
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam state_t                RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    // Storage is deliberately not reset; only the clear sweep gives it a known value.
    logic [BITS-1:0] mem [WORD_DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  p1_vld_q, p1_vld_d;
    logic [BITS-1:0]       p1_dat_q, p1_dat_d;
    logic [BITS-1:0]       rd_q, rd_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  accept;
    logic                  rd_fire;
    logic                  in_range;
    logic [BITS-1:0]       rd_sample;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [BITS-1:0]       mem_wdat;
    logic [BITS-1:0]       mem_wmask;

    // ready_q is only ever high in IDLE, so accept implies IDLE.
    assign accept    = ce_in & ready_q;
    assign rd_fire   = accept & ~we_in;
    assign in_range  = ({1'b0, addr_in} < DEPTH_EXT);
    assign rd_sample = in_range ? mem[addr_in] : '0;

    // Select the array write port: the sweep owns it in CLEAR, accepted in-range writes in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdat  = '0;
        mem_wmask = '0;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdat  = CLEAR_VALUE;
            mem_wmask = '1;
        end else if (accept && we_in && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = addr_in;
            mem_wdat  = wd_in;
            mem_wmask = w_mask_in;
        end
    end

    // Bit-masked array write; an accepted request with unknown control poisons the whole array.
    always_ff @(posedge clk) begin
        if (corrupt_mem_on_X_p && accept && $isunknown({we_in, addr_in})) begin
            for (int i = 0; i < WORD_DEPTH; i++) begin
                mem[i] <= {BITS{1'bx}};
            end
        end else if (mem_we) begin
            mem[mem_waddr] <= (mem[mem_waddr] & ~mem_wmask) | (mem_wdat & mem_wmask);
        end
    end

    // Clear/idle sequencing and the sweep address counter; a clear request in IDLE
    // is taken on the same edge as any accompanying access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clr_in) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
                ready_d = (RST_STATE == ST_IDLE);
            end
        endcase
    end

    // Read return path: the data is captured at the accepting edge and, for latency 2,
    // parked one cycle in p1 before reaching rd_q. rd_q holds between reads.
    always_comb begin
        rd_d     = rd_q;
        rd_vld_d = 1'b0;
        p1_vld_d = 1'b0;
        p1_dat_d = p1_dat_q;
        if (READ_LATENCY == 2) begin
            p1_vld_d = rd_fire;
            if (rd_fire) begin
                p1_dat_d = rd_sample;
            end
            if (p1_vld_q) begin
                rd_d     = p1_dat_q;
                rd_vld_d = 1'b1;
            end
        end else begin
            if (rd_fire) begin
                rd_d     = rd_sample;
                rd_vld_d = 1'b1;
            end
        end
    end

    // Control and read-pipeline registers; reset aborts any sweep or pending read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            ready_q  <= (RST_STATE == ST_IDLE);
            p1_vld_q <= 1'b0;
            p1_dat_q <= '0;
            rd_q     <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            p1_vld_q <= p1_vld_d;
            p1_dat_q <= p1_dat_d;
            rd_q     <= rd_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    assign ready_out    = ready_q;
    assign rd_out       = rd_q;
    assign rd_valid_out = rd_vld_q;

endmodule

// File: tb/tb_fakeram130_1rw_clr.sv
// Bench for fakeram130_1rw_clr: A = 64x512 latency 1, B = 64x300 latency 2 clear 5A,
// C = no clear on reset. A and B share request fields; each has its own ce.
// Read expectations are queued with their due cycle and popped when rd_valid_out pulses.
module tb_fakeram130_1rw_clr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_a, ce_b, we, clr;
    logic [8:0]  addr;
    logic [63:0] wd, mask;

    logic        ready_a, vld_a, ready_b, vld_b, ready_c, vld_c;
    logic [63:0] rd_a, rd_b;
    logic [7:0]  rd_c;

    always #5 clk = ~clk;

    fakeram130_1rw_clr #(.BITS(64), .WORD_DEPTH(512), .READ_LATENCY(1),
                         .CLEAR_ON_RESET(1), .CLEAR_VALUE(64'h0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_a), .we_in(we), .addr_in(addr),
        .wd_in(wd), .w_mask_in(mask), .clr_in(clr),
        .ready_out(ready_a), .rd_out(rd_a), .rd_valid_out(vld_a));

    fakeram130_1rw_clr #(.BITS(64), .WORD_DEPTH(300), .READ_LATENCY(2),
                         .CLEAR_ON_RESET(1), .CLEAR_VALUE(64'h5A)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ce_in(ce_b), .we_in(we), .addr_in(addr),
        .wd_in(wd), .w_mask_in(mask), .clr_in(clr),
        .ready_out(ready_b), .rd_out(rd_b), .rd_valid_out(vld_b));

    fakeram130_1rw_clr #(.BITS(8), .WORD_DEPTH(4), .READ_LATENCY(1),
                         .CLEAR_ON_RESET(0), .CLEAR_VALUE(8'h00)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .ce_in(1'b0), .we_in(1'b0), .addr_in(2'b00),
        .wd_in(8'h00), .w_mask_in(8'h00), .clr_in(1'b0),
        .ready_out(ready_c), .rd_out(rd_c), .rd_valid_out(vld_c));

    typedef struct {
        logic [63:0] dat;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [63:0] wd;
        logic [63:0] mask;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] last_a = '0;
    logic [63:0] last_b = '0;
    vec_t        tbl[19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pulse must match the head of its queue in data and cycle;
    // between pulses rd_out must hold its last value.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset_n) begin
            last_a = '0;
            last_b = '0;
        end else begin
            if (vld_a) begin
                if (qa.size() == 0) chk("a_spurious_vld", {63'b0, vld_a}, 64'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_rd_dat", rd_a, e.dat);
                    chk("a_rd_cycle", 64'(cyc), 64'(e.due));
                end
                last_a = rd_a;
            end else chk("a_rd_hold", rd_a, last_a);
            if (vld_b) begin
                if (qb.size() == 0) chk("b_spurious_vld", {63'b0, vld_b}, 64'd0);
                else begin
                    e = qb.pop_front();
                    chk("b_rd_dat", rd_b, e.dat);
                    chk("b_rd_cycle", 64'(cyc), 64'(e.due));
                end
                last_b = rd_b;
            end else chk("b_rd_hold", rd_b, last_b);
        end
    end

    // Counts edges until each ready_out rises; a missed bound reports -1.
    task automatic wait_ready(input string nm, input int exp_na, input int exp_nb);
        int n  = 0;
        int na = -1;
        int nb = -1;
        while ((na < 0 || nb < 0) && n < 2000) begin
            @(negedge clk);
            n++;
            if (na < 0 && ready_a) na = n;
            if (nb < 0 && ready_b) nb = n;
        end
        chk({nm, "_a_clear_edges"}, 64'(na), 64'(exp_na));
        chk({nm, "_b_clear_edges"}, 64'(nb), 64'(exp_nb));
    endtask

    task automatic issue_read(input logic [8:0] a, input logic [63:0] ea, input logic [63:0] eb);
        ce_a = 1'b1; ce_b = 1'b1; we = 1'b0; addr = a;
        qa.push_back('{ea, cyc + 1});
        qb.push_back('{eb, cyc + 2});
        @(negedge clk);
        ce_a = 1'b0; ce_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 9'd5,   64'h0,                  64'h0,                  64'h0,                  64'h5A};
        tbl[1]  = '{1'b1, 9'd7,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  64'h0};
        tbl[2]  = '{1'b1, 9'd7,   64'h0,                  64'h0000_0000_FFFF_0000, 64'h0,                  64'h0};
        tbl[3]  = '{1'b0, 9'd7,   64'h0,                  64'h0,                  64'hFFFF_FFFF_0000_FFFF, 64'hFFFF_FFFF_0000_FFFF};
        tbl[4]  = '{1'b1, 9'd0,   64'd10,                 '1,                     64'h0,                  64'h0};
        tbl[5]  = '{1'b1, 9'd1,   64'd11,                 '1,                     64'h0,                  64'h0};
        tbl[6]  = '{1'b1, 9'd2,   64'd12,                 '1,                     64'h0,                  64'h0};
        tbl[7]  = '{1'b1, 9'd3,   64'd13,                 '1,                     64'h0,                  64'h0};
        tbl[8]  = '{1'b0, 9'd0,   64'h0,                  64'h0,                  64'd10,                 64'd10};
        tbl[9]  = '{1'b0, 9'd1,   64'h0,                  64'h0,                  64'd11,                 64'd11};
        tbl[10] = '{1'b0, 9'd2,   64'h0,                  64'h0,                  64'd12,                 64'd12};
        tbl[11] = '{1'b0, 9'd3,   64'h0,                  64'h0,                  64'd13,                 64'd13};
        tbl[12] = '{1'b1, 9'd310, 64'h1234,               '1,                     64'h0,                  64'h0};
        tbl[13] = '{1'b0, 9'd310, 64'h0,                  64'h0,                  64'h1234,               64'h0};
        tbl[14] = '{1'b0, 9'd299, 64'h0,                  64'h0,                  64'h0,                  64'h5A};
        tbl[15] = '{1'b1, 9'd9,   64'hAB,                 64'h0,                  64'h0,                  64'h0};
        tbl[16] = '{1'b0, 9'd9,   64'h0,                  64'h0,                  64'h0,                  64'h5A};
        tbl[17] = '{1'b1, 9'd8,   64'h0F,                 64'h3C,                 64'h0,                  64'h0};
        tbl[18] = '{1'b0, 9'd8,   64'h0,                  64'h0,                  64'h0C,                 64'h4E};

        reset_n = 1'b1;
        ce_a = 1'b0; ce_b = 1'b0; we = 1'b0; clr = 1'b0;
        addr = '0; wd = '0; mask = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_ready_a", {63'b0, ready_a}, 64'd0);
        chk("rst_ready_b", {63'b0, ready_b}, 64'd0);
        chk("rst_ready_c", {63'b0, ready_c}, 64'd1);
        chk("rst_rd_a", rd_a, 64'h0);
        chk("rst_rd_b", rd_b, 64'h0);
        chk("rst_rd_c", {56'b0, rd_c}, 64'h0);
        chk("rst_vld", {61'b0, vld_a, vld_b, vld_c}, 64'h0);

        // A keeps asking for a read of 5 throughout the sweep.
        ce_a = 1'b1; we = 1'b0; addr = 9'd5;
        #2 reset_n = 1'b1;
        wait_ready("rst", 512, 300);
        chk("c_ready_after_rst", {63'b0, ready_c}, 64'd1);
        qa.push_back('{64'h0, cyc + 1});
        @(negedge clk);
        ce_a = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            ce_a = 1'b1; ce_b = 1'b1;
            we = tbl[i].we; addr = tbl[i].addr; wd = tbl[i].wd; mask = tbl[i].mask;
            if (!tbl[i].we) begin
                qa.push_back('{tbl[i].exp_a, cyc + 1});
                qb.push_back('{tbl[i].exp_b, cyc + 2});
            end
            @(negedge clk);
        end
        ce_a = 1'b0; ce_b = 1'b0; we = 1'b0;
        repeat (4) @(negedge clk);

        // Read one edge before a clear; then write together with the clear.
        ce_a = 1'b1; ce_b = 1'b1; we = 1'b0; addr = 9'd3;
        qa.push_back('{64'd13, cyc + 1});
        qb.push_back('{64'd13, cyc + 2});
        @(negedge clk);
        we = 1'b1; addr = 9'd3; wd = 64'hAA; mask = '1; clr = 1'b1;
        @(negedge clk);
        ce_a = 1'b0; ce_b = 1'b0; we = 1'b0; clr = 1'b0;
        chk("clr_ready_drop", {62'b0, ready_a, ready_b}, 64'h0);
        wait_ready("clr", 512, 300);
        issue_read(9'd3, 64'h0, 64'h5A);
        repeat (3) @(negedge clk);

        // Reset during a sweep, with rd_out holding non-zero data.
        ce_a = 1'b1; ce_b = 1'b1; we = 1'b1; addr = 9'd7;
        wd = 64'h0123_4567_89AB_CDEF; mask = '1;
        @(negedge clk);
        we = 1'b0; clr = 1'b1;
        qa.push_back('{64'h0123_4567_89AB_CDEF, cyc + 1});
        qb.push_back('{64'h0123_4567_89AB_CDEF, cyc + 2});
        @(negedge clk);
        ce_a = 1'b0; ce_b = 1'b0; clr = 1'b0;
        repeat (99) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ready", {62'b0, ready_a, ready_b}, 64'h0);
        chk("midrst_rd_a", rd_a, 64'h0);
        chk("midrst_rd_b", rd_b, 64'h0);
        chk("midrst_vld", {62'b0, vld_a, vld_b}, 64'h0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        wait_ready("rst2", 512, 300);
        issue_read(9'd7, 64'h0, 64'h5A);
        issue_read(9'd5, 64'h0, 64'h5A);

        repeat (4) @(negedge clk);
        chk("a_queue_drained", 64'(qa.size()), 64'd0);
        chk("b_queue_drained", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
